// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one 4-bit ALU among NREQ requesters.
// One op in flight: capture operands, execute, hold the tagged response until consumed.

module alu (
  input  logic [3:0] op_a_i,
  input  logic [3:0] op_b_i,
  input  logic [2:0] opcode_i,
  output logic [7:0] result_o
);
  logic [7:0] a8;
  logic [7:0] b8;

  // Operands are zero-extended first, so not/xnor produce an F upper nibble.
  assign a8 = {4'h0, op_a_i};
  assign b8 = {4'h0, op_b_i};

  always_comb begin
    result_o = 8'h00;
    unique case (opcode_i)
      3'b000: result_o = a8 + b8;
      3'b001: result_o = a8 - b8;
      3'b010: result_o = a8 * b8;
      3'b011: result_o = a8 & b8;
      3'b100: result_o = a8 | b8;
      3'b101: result_o = ~a8;
      3'b110: result_o = a8 ^ b8;
      3'b111: result_o = ~(a8 ^ b8);
    endcase
  end
endmodule

module alu_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_opA,
  input  logic [4*NREQ-1:0]    req_opB,
  input  logic [3*NREQ-1:0]    req_opcode,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_result,
  output logic                 busy,
  output logic [15:0]          op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] rr_ptr_d;
  logic [3:0]      op_a_q;
  logic [3:0]      op_b_q;
  logic [2:0]      opcode_q;
  logic [ID_W-1:0] id_q;
  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [7:0]      rsp_result_q;
  logic [15:0]     op_count_q;
  logic [15:0]     op_count_d;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand;
  logic [NREQ-1:0] gnt_onehot;
  logic [7:0]      alu_result;

  // Search starts at rr_ptr and wraps, so the last grantee is looked at last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ID_W'((int'(rr_ptr_q) + i) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt_onehot = '0;
    if (gnt_found) gnt_onehot[gnt_idx] = 1'b1;
    req_ready = '0;
    if (rst_n && state_q == IDLE) req_ready = gnt_onehot;
  end

  assign rr_ptr_d   = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
  assign op_count_d = (op_count_q == 16'hFFFF) ? op_count_q : op_count_q + 16'd1;

  alu u_alu (
    .op_a_i   (op_a_q),
    .op_b_i   (op_b_q),
    .opcode_i (opcode_q),
    .result_o (alu_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      opcode_q     <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            op_a_q   <= req_opA[4*gnt_idx +: 4];
            op_b_q   <= req_opB[4*gnt_idx +: 4];
            opcode_q <= req_opcode[3*gnt_idx +: 3];
            id_q     <= gnt_idx;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = op_count_q;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: opcode vector table, directed corner sequences,
// then random traffic checked against a transaction-level reference model.

module tb_alu_rr_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_opA;
  logic [15:0] req_opB;
  logic [11:0] req_opcode;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_result;
  logic        busy;
  logic [15:0] op_count;

  int checks = 0;
  int failures = 0;

  alu_rr_scheduler #(.NREQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opA    (req_opA),
    .req_opB    (req_opB),
    .req_opcode (req_opcode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    req_opA[4*i +: 4]    = a;
    req_opB[4*i +: 4]    = b;
    req_opcode[3*i +: 3] = op;
  endtask

  function automatic int alu_ref(input int a, input int b, input int op);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a * b;
      3: return a & b;
      4: return a | b;
      5: return 255 - a;
      6: return a ^ b;
      default: return 255 - (a ^ b);
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input vec_t v);
    logic got;
    @(negedge clk);
    rsp_ready = 1'b1;
    set_ops(v.idx, v.a, v.b, v.op);
    req_valid = 4'(1 << v.idx);
    #1;
    chk("vec_grant", req_ready, 32'(1 << v.idx));
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      got = rsp_valid;
    end
    chk("vec_rsp_seen", got, 1);
    chk("vec_result", rsp_result, v.exp);
    chk("vec_id", rsp_id, v.idx);
  endtask

  // Reference model state (transaction level)
  bit [3:0] pend;
  int pa[4], pb[4], po[4];
  int m_ptr, m_age, m_id, m_res, m_cnt, g;
  bit m_inflight;
  int exp_ids[5] = '{0, 1, 2, 3, 0};

  initial begin
    vt[0] = '{0, 4'h3, 4'h5, 3'b001, 8'hFE};
    vt[1] = '{1, 4'hF, 4'hF, 3'b010, 8'hE1};
    vt[2] = '{2, 4'h3, 4'h9, 3'b101, 8'hFC};
    vt[3] = '{3, 4'hA, 4'h5, 3'b111, 8'hF0};
    vt[4] = '{0, 4'hF, 4'hF, 3'b000, 8'h1E};
    vt[5] = '{1, 4'hC, 4'hA, 3'b011, 8'h08};
    vt[6] = '{2, 4'hC, 4'h3, 3'b100, 8'h0F};
    vt[7] = '{3, 4'h9, 4'h6, 3'b110, 8'h0F};
    vt[8] = '{0, 4'h7, 4'h3, 3'b010, 8'h15};
    vt[9] = '{1, 4'h0, 4'h1, 3'b001, 8'hFF};

    rst_n = 1'b0;
    req_valid = 4'hF;
    req_opA = '0;
    req_opB = '0;
    req_opcode = '0;
    rsp_ready = 1'b0;

    // Reset with all requests asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    rst_n = 1'b1;
    req_valid = '0;

    // Single op latency
    @(negedge clk);
    set_ops(0, 4'h3, 4'h5, 3'b001);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    chk("single_grant_c0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("single_c1_valid", rsp_valid, 0);
    chk("single_c1_busy", busy, 1);
    chk("single_c1_ready", req_ready, 0);
    @(negedge clk);
    #1;
    chk("single_c2_valid", rsp_valid, 1);
    chk("single_c2_result", rsp_result, 8'hFE);
    chk("single_c2_id", rsp_id, 0);
    @(negedge clk);
    #1;
    chk("single_c3_valid", rsp_valid, 0);
    chk("single_c3_busy", busy, 0);
    chk("single_c3_count", op_count, 1);

    for (int k = 0; k < 10; k++) run_op(vt[k]);

    // Fairness with all requesters held
    do_reset();
    begin
      int n;
      n = 0;
      for (int i = 0; i < 4; i++) set_ops(i, 4'(i + 1), 4'h2, 3'b000);
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      for (int c = 0; c < 40 && n < 5; c++) begin
        @(negedge clk);
        #1;
        if (rsp_valid) begin
          chk("fair_id", rsp_id, exp_ids[n]);
          chk("fair_result", rsp_result, exp_ids[n] + 3);
          n++;
        end
      end
      chk("fair_rsp_count", n, 5);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("fair_op_count", op_count, 5);
      chk("fair_idle", busy, 0);
    end

    // Backpressure, with new requests arriving while busy
    @(negedge clk);
    rsp_ready = 1'b0;
    set_ops(2, 4'h7, 4'h9, 3'b000);
    req_valid = 4'b0100;
    #1;
    chk("bp_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b1011;
    #1;
    chk("bp_exec_busy", busy, 1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_result", rsp_result, 8'h10);
      chk("bp_hold_id", rsp_id, 2);
      chk("bp_hold_busy", busy, 1);
      chk("bp_hold_ready", req_ready, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_valid", rsp_valid, 1);
    @(negedge clk);
    #1;
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_after_busy", busy, 0);
    chk("bp_after_count", op_count, 6);
    chk("bp_waiting_grant", req_ready, 4'b1000);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("bp_single_handshake", op_count, 6);
    chk("bp_stays_idle", busy, 0);

    // Reset during EXEC
    @(negedge clk);
    set_ops(2, 4'h1, 4'h1, 3'b000);
    req_valid = 4'b0100;
    #1;
    chk("mid_grant", req_ready, 4'b0100);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b1010;
    #1;
    chk("mid_exec_busy", busy, 1);
    chk("mid_rst_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_no_rsp", rsp_valid, 0);
    chk("mid_idle", busy, 0);
    chk("mid_count", op_count, 0);
    chk("mid_lowest_grant", req_ready, 4'b0010);
    begin
      logic got;
      got = 1'b0;
      for (int n = 0; n < 8 && !got; n++) begin
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        got = rsp_valid;
      end
      chk("mid_rsp_seen", got, 1);
      chk("mid_rsp_id", rsp_id, 1);
      req_valid = '0;
    end

    // Random traffic against the reference model
    do_reset();
    pend = '0;
    m_ptr = 0;
    m_age = 0;
    m_id = 0;
    m_res = 0;
    m_cnt = 0;
    m_inflight = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(3) == 0) begin
            pend[i] = 1'b1;
            pa[i] = int'($urandom_range(15));
            pb[i] = int'($urandom_range(15));
            po[i] = int'($urandom_range(7));
          end
        end else if ($urandom_range(31) == 0) begin
          pend[i] = 1'b0;
        end
        set_ops(i, 4'(pa[i]), 4'(pb[i]), 3'(po[i]));
      end
      req_valid = pend;
      rsp_ready = ($urandom_range(2) != 0);
      g = -1;
      if (!m_inflight)
        for (int k = 0; k < 4; k++)
          if (g < 0 && pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      #1;
      chk("rnd_req_ready", req_ready, (g >= 0) ? 32'(1 << g) : 0);
      chk("rnd_rsp_valid", rsp_valid, (m_inflight && m_age >= 1) ? 1 : 0);
      chk("rnd_busy", busy, m_inflight ? 1 : 0);
      chk("rnd_op_count", op_count, m_cnt);
      if (m_inflight && m_age >= 1) begin
        chk("rnd_rsp_id", rsp_id, m_id);
        chk("rnd_rsp_result", rsp_result, m_res);
      end
      if (m_inflight) begin
        if (m_age >= 1 && rsp_ready) begin
          m_inflight = 1'b0;
          if (m_cnt < 65535) m_cnt++;
        end else begin
          m_age++;
        end
      end else if (g >= 0) begin
        m_inflight = 1'b1;
        m_age = 0;
        m_id = g;
        m_res = alu_ref(pa[g], pb[g], po[g]);
        m_ptr = (g + 1) % 4;
        pend[g] = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
